// File: rtl/fpu_arb_pkg.sv
// fpu_arb_pkg
// Shared definitions for the fadd/fsub arbiter slice.
// Contents: the arbiter state encoding, the add/sub Funct encodings and the
// requester-ID width. The arbiter top and its grant sub-module import it.
package fpu_arb_pkg;

  localparam int ID_W = 1;

  localparam logic FUNCT_ADD = 1'b0;
  localparam logic FUNCT_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fpu_arb_grant.sv
// fpu_arb_grant
// Two-input arbiter that chooses which requester the fadd/fsub arbiter
// serves next.
// Build option FPU_ARB_ROUND_ROBIN_EN:
//   defined   - round robin; a 1-bit pointer names the favoured requester
//               and moves to the other ID on every accepted handshake.
//   undefined - fixed priority; requester 0 always wins when valid. There is
//               no pointer, so the clk/rst/i_accept ports are not present.
// Ports:
//   clk, rst     clock and synchronous active-high reset (round robin only)
//   i_accept     a handshake is accepted this cycle (round robin only)
//   i_valid0/1   requester valids
//   o_grant0/1   one-hot grant; both low when neither requester is valid
//   o_grant_id   ID of the granted requester
module fpu_arb_grant
  import fpu_arb_pkg::*;
(
`ifdef FPU_ARB_ROUND_ROBIN_EN
  input  logic            clk,
  input  logic            rst,
  input  logic            i_accept,
`endif
  input  logic            i_valid0,
  input  logic            i_valid1,
  output logic            o_grant0,
  output logic            o_grant1,
  output logic [ID_W-1:0] o_grant_id
);

`ifdef FPU_ARB_ROUND_ROBIN_EN
  logic r_ptr;

  // When both requesters are valid, the pointer breaks the tie. A lone
  // requester wins straight away, whatever the pointer says.
  always_comb begin
    o_grant0 = i_valid0 & (~i_valid1 | ~r_ptr);
    o_grant1 = i_valid1 & (~i_valid0 |  r_ptr);
  end

  // After an accepted grant, favour the requester that did not win.
  // Continuous contention then alternates 0,1,0,1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= ~o_grant_id;
    end
  end
`else
  // Fixed priority: requester 0 shadows requester 1. If requester 0 keeps
  // its valid high, requester 1 starves.
  always_comb begin
    o_grant0 = i_valid0;
    o_grant1 = i_valid1 & ~i_valid0;
  end
`endif

  assign o_grant_id = o_grant1;

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// fpu_addsub_arbiter
// Lets two requesters share one fadd_fsub unit, with one operation in
// flight at a time. The chosen request's operands are registered onto the
// unit inputs and held for LAT cycles. The result is then captured from frd
// and returned with the requester ID over a valid/ready response channel.
// Build option FPU_ARB_ROUND_ROBIN_EN chooses round-robin arbitration.
// Without it, arbitration is fixed priority with req0 first.
// Parameters: XLEN operand width, LAT cycles the unit inputs are held (>=1).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   reqN_valid/ready           request handshake for requester N (0/1)
//   reqN_frs1/frs2/funct       operands and op (0 add, 1 sub)
//   rsp_valid/ready            response handshake
//   rsp_frd, rsp_id            result and ID of the issuing requester
//   fu_frs1/frs2/funct/en      drive the shared unit
//   fu_rst_n                   unit reset, the inverse of rst
//   fu_frd                     unit result
module fpu_addsub_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_frs1,
  input  logic [XLEN-1:0] req0_frs2,
  input  logic            req0_funct,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_frs1,
  input  logic [XLEN-1:0] req1_frs2,
  input  logic            req1_funct,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_frd,
  output logic            rsp_id,
  output logic [XLEN-1:0] fu_frs1,
  output logic [XLEN-1:0] fu_frs2,
  output logic            fu_funct,
  output logic            fu_en,
  output logic            fu_rst_n,
  input  logic [XLEN-1:0] fu_frd
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  arb_state_e       r_state;
  arb_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_frs1;
  logic [XLEN-1:0]  r_frs2;
  logic             r_funct;
  logic [XLEN-1:0]  r_frd;
  logic [ID_W-1:0]  r_id;
  logic             w_grant0;
  logic             w_grant1;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_accept;

  // A grant is only ever issued to a requester that is valid. That makes
  // "IDLE and someone is granted" the same thing as an accepted handshake.
  assign w_accept = (r_state == IDLE) & (w_grant0 | w_grant1);

  fpu_arb_grant u_grant (
`ifdef FPU_ARB_ROUND_ROBIN_EN
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_accept),
`endif
    .i_valid0   (req0_valid),
    .i_valid1   (req1_valid),
    .o_grant0   (w_grant0),
    .o_grant1   (w_grant1),
    .o_grant_id (w_grant_id)
  );

  // State register. A reset at any point, including mid-operation, drops
  // the operation without producing a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and the handshake/enable outputs. Ready is offered only in
  // IDLE, so nothing is sampled while an operation is in flight.
  always_comb begin
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    fu_en        = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        if (w_accept) begin
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        fu_en = 1'b1;
        if (r_cnt == '0) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath. Operands load only on an accepted handshake and stay put
  // through EXEC. The result and ID stay put through RESP and afterwards,
  // until the next operation overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_frs1  <= '0;
      r_frs2  <= '0;
      r_funct <= FUNCT_ADD;
      r_frd   <= '0;
      r_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_grant1) begin
              r_frs1  <= req1_frs1;
              r_frs2  <= req1_frs2;
              r_funct <= req1_funct;
            end else begin
              r_frs1  <= req0_frs1;
              r_frs2  <= req0_frs2;
              r_funct <= req0_funct;
            end
            r_id  <= w_grant_id;
            r_cnt <= CNT_W'(LAT - 1);
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_frd <= fu_frd;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign fu_frs1  = r_frs1;
  assign fu_frs2  = r_frs2;
  assign fu_funct = r_funct;
  assign fu_rst_n = ~rst;
  assign rsp_frd  = r_frd;
  assign rsp_id   = r_id;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb_fpu_addsub_arbiter
// Self-checking bench for fpu_addsub_arbiter. It drives one LAT=1 instance
// and one LAT=3 instance. A small lookup model stands in for the fadd_fsub
// unit and returns the hand-computed binary32 results for the operands used
// here. Expected values for FPU_ARB_ROUND_ROBIN_EN follow the macro.
module tb_fpu_addsub_arbiter;
  import fpu_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0Valid, req0Ready, req0Funct;
  logic [31:0] req0Frs1, req0Frs2;
  logic        req1Valid, req1Ready, req1Funct;
  logic [31:0] req1Frs1, req1Frs2;
  logic        rspValid, rspReady, rspId;
  logic [31:0] rspFrd;
  logic [31:0] fuFrs1, fuFrs2, fuFrd;
  logic        fuFunct, fuEn, fuRstN;

  logic        req0ValidL3, req0ReadyL3, req0FunctL3, req1ReadyL3;
  logic [31:0] req0Frs1L3, req0Frs2L3;
  logic        rspValidL3, rspReadyL3, rspIdL3;
  logic [31:0] rspFrdL3;
  logic [31:0] fuFrs1L3, fuFrs2L3, fuFrdL3;
  logic        fuFunctL3, fuEnL3, fuRstNL3;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        useReq1;
    logic [31:0] frs1;
    logic [31:0] frs2;
    logic        funct;
    logic [31:0] expFrd;
    logic        expId;
  } vec_t;

  vec_t vecs[5];

  // Stand-in for the fadd_fsub unit. The results are hand-computed binary32
  // values. An idle unit (En low) outputs zero.
  function automatic logic [31:0] fakeUnit(input logic [31:0] a, input logic [31:0] b,
                                           input logic f);
    case ({f, a, b})
      {FUNCT_ADD, 32'h40200000, 32'h00000000}: return 32'h40200000;
      {FUNCT_ADD, 32'hC0200000, 32'h3FA00000}: return 32'hBFA00000;
      {FUNCT_SUB, 32'hC0200000, 32'h3FA00000}: return 32'hC0700000;
      {FUNCT_SUB, 32'h40000000, 32'h3F800000}: return 32'h3F800000;
      {FUNCT_ADD, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {FUNCT_ADD, 32'h40400000, 32'h40800000}: return 32'h40E00000;
      {FUNCT_SUB, 32'h41200000, 32'h40A00000}: return 32'h40A00000;
      default: return 32'hDEADBEEF ^ a;
    endcase
  endfunction

  assign fuFrd   = fuEn   ? fakeUnit(fuFrs1, fuFrs2, fuFunct) : 32'h0;
  assign fuFrdL3 = fuEnL3 ? fakeUnit(fuFrs1L3, fuFrs2L3, fuFunctL3) : 32'h0;

  fpu_addsub_arbiter #(.XLEN(32), .LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0Valid), .req0_ready(req0Ready), .req0_frs1(req0Frs1),
    .req0_frs2(req0Frs2), .req0_funct(req0Funct),
    .req1_valid(req1Valid), .req1_ready(req1Ready), .req1_frs1(req1Frs1),
    .req1_frs2(req1Frs2), .req1_funct(req1Funct),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_frd(rspFrd), .rsp_id(rspId),
    .fu_frs1(fuFrs1), .fu_frs2(fuFrs2), .fu_funct(fuFunct), .fu_en(fuEn),
    .fu_rst_n(fuRstN), .fu_frd(fuFrd)
  );

  fpu_addsub_arbiter #(.XLEN(32), .LAT(3)) dutL3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0ValidL3), .req0_ready(req0ReadyL3), .req0_frs1(req0Frs1L3),
    .req0_frs2(req0Frs2L3), .req0_funct(req0FunctL3),
    .req1_valid(1'b0), .req1_ready(req1ReadyL3), .req1_frs1(32'h0),
    .req1_frs2(32'h0), .req1_funct(1'b0),
    .rsp_valid(rspValidL3), .rsp_ready(rspReadyL3), .rsp_frd(rspFrdL3), .rsp_id(rspIdL3),
    .fu_frs1(fuFrs1L3), .fu_frs2(fuFrs2L3), .fu_funct(fuFunctL3), .fu_en(fuEnL3),
    .fu_rst_n(fuRstNL3), .fu_frd(fuFrdL3)
  );

  // Step to 1 ns after the next rising edge. All driving and sampling
  // happens there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    req0Valid = 1'b0; req0Frs1 = '0; req0Frs2 = '0; req0Funct = 1'b0;
    req1Valid = 1'b0; req1Frs1 = '0; req1Frs2 = '0; req1Funct = 1'b0;
    rspReady = 1'b1;
    req0ValidL3 = 1'b0; req0Frs1L3 = '0; req0Frs2L3 = '0; req0FunctL3 = 1'b0;
    rspReadyL3 = 1'b1;
    tick();
    checkOutput("reset fu_rst_n", {31'b0, fuRstN}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset fu_en", {31'b0, fuEn}, 32'h0);
    checkOutput("reset rsp_valid", {31'b0, rspValid}, 32'h0);
    checkOutput("reset rsp_frd", rspFrd, 32'h0);
    checkOutput("reset rsp_id", {31'b0, rspId}, 32'h0);
    checkOutput("reset fu_frs1", fuFrs1, 32'h0);
    checkOutput("reset fu_frs2", fuFrs2, 32'h0);
    checkOutput("reset fu_funct", {31'b0, fuFunct}, 32'h0);
    checkOutput("reset fu_rst_n released", {31'b0, fuRstN}, 32'h1);
  endtask

  // Called just after the accepting edge. Counts edges from that edge
  // (inclusive) until rsp_valid appears. Checks the latency, the result,
  // the ID, and that no ready was offered meanwhile.
  task automatic waitRsp(input string tag, input logic [31:0] expFrd, input logic expId,
                         input int expEdges);
    int edges = 1;
    logic sawReady = 1'b0;
    while (!rspValid && edges < 20) begin
      sawReady |= req0Ready | req1Ready;
      tick();
      edges++;
    end
    checkOutput({tag, " latency"}, edges, expEdges);
    checkOutput({tag, " rsp_frd"}, rspFrd, expFrd);
    checkOutput({tag, " rsp_id"}, {31'b0, rspId}, {31'b0, expId});
    checkOutput({tag, " ready in flight"}, {31'b0, sawReady}, 32'h0);
  endtask

  // Issue a single request from one requester and follow it to completion,
  // with rsp_ready held high.
  task automatic applyStimulus(input string tag, input vec_t v);
    int waitCycles = 0;
    logic myReady, otherReady;
    rspReady = 1'b1;
    if (v.useReq1) begin
      req1Valid = 1'b1; req1Frs1 = v.frs1; req1Frs2 = v.frs2; req1Funct = v.funct;
    end else begin
      req0Valid = 1'b1; req0Frs1 = v.frs1; req0Frs2 = v.frs2; req0Funct = v.funct;
    end
    #1;
    myReady = v.useReq1 ? req1Ready : req0Ready;
    while (!myReady && waitCycles < 10) begin
      tick();
      waitCycles++;
      myReady = v.useReq1 ? req1Ready : req0Ready;
    end
    otherReady = v.useReq1 ? req0Ready : req1Ready;
    checkOutput({tag, " ready"}, {31'b0, myReady}, 32'h1);
    checkOutput({tag, " other ready"}, {31'b0, otherReady}, 32'h0);
    tick();
    // Drop valid and scramble the operands. Any late sampling then shows up
    // as a wrong result.
    req0Valid = 1'b0; req1Valid = 1'b0;
    req0Frs1 = 32'hFFFFFFFF; req0Frs2 = 32'hFFFFFFFF;
    req1Frs1 = 32'hFFFFFFFF; req1Frs2 = 32'hFFFFFFFF;
    #1;
    waitRsp(tag, v.expFrd, v.expId, 2);
    tick();
    checkOutput({tag, " rsp_valid cleared"}, {31'b0, rspValid}, 32'h0);
    checkOutput({tag, " rsp_frd retained"}, rspFrd, v.expFrd);
  endtask

  initial begin
    logic [31:0] heldFrd;
    logic        expId;
    logic        sawReq1;

    vecs[0] = '{1'b0, 32'h40200000, 32'h00000000, FUNCT_ADD, 32'h40200000, 1'b0};
    vecs[1] = '{1'b1, 32'hC0200000, 32'h3FA00000, FUNCT_ADD, 32'hBFA00000, 1'b1};
    vecs[2] = '{1'b0, 32'hC0200000, 32'h3FA00000, FUNCT_SUB, 32'hC0700000, 1'b0};
    vecs[3] = '{1'b1, 32'h40000000, 32'h3F800000, FUNCT_SUB, 32'h3F800000, 1'b1};
    vecs[4] = '{1'b0, 32'h3F800000, 32'h3F800000, FUNCT_ADD, 32'h40000000, 1'b0};

    $display("[TB] reset");
    resetDut();

    $display("[TB] single-requester vectors");
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: the response holds for 5 cycles while requester 1 waits
    // and must not be offered ready.
    $display("[TB] response backpressure");
    rspReady = 1'b0;
    req0Valid = 1'b1; req0Frs1 = 32'hC0200000; req0Frs2 = 32'h3FA00000; req0Funct = FUNCT_SUB;
    #1;
    checkOutput("stall ready0", {31'b0, req0Ready}, 32'h1);
    tick();
    req0Valid = 1'b0;
    req1Valid = 1'b1; req1Frs1 = 32'h3F800000; req1Frs2 = 32'h3F800000; req1Funct = FUNCT_ADD;
    #1;
    waitRsp("stall", 32'hC0700000, 1'b0, 2);
    heldFrd = rspFrd;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("stall c%0d rsp_valid", k), {31'b0, rspValid}, 32'h1);
      checkOutput($sformatf("stall c%0d rsp_frd", k), rspFrd, heldFrd);
      checkOutput($sformatf("stall c%0d readies", k), {30'b0, req0Ready, req1Ready}, 32'h0);
    end
    rspReady = 1'b1;
    tick();
    checkOutput("stall release rsp_valid", {31'b0, rspValid}, 32'h0);
    checkOutput("stall release ready1", {31'b0, req1Ready}, 32'h1);
    tick();
    req1Valid = 1'b0;
    #1;
    waitRsp("queued req1", 32'h40000000, 1'b1, 2);
    tick();

    // Both requesters hold valid through four operations.
    $display("[TB] contention");
    resetDut();
    req0Valid = 1'b1; req0Frs1 = 32'h40400000; req0Frs2 = 32'h40800000; req0Funct = FUNCT_ADD;
    req1Valid = 1'b1; req1Frs1 = 32'h41200000; req1Frs2 = 32'h40A00000; req1Funct = FUNCT_SUB;
    sawReq1 = 1'b0;
    #1;
    for (int op = 0; op < 4; op++) begin
`ifdef FPU_ARB_ROUND_ROBIN_EN
      expId = op[0];
`else
      expId = 1'b0;
`endif
      sawReq1 |= req1Ready;
      checkOutput($sformatf("contend op%0d one-hot", op), {31'b0, req0Ready ^ req1Ready}, 32'h1);
      checkOutput($sformatf("contend op%0d grant", op), {31'b0, req1Ready}, {31'b0, expId});
      tick();
      waitRsp($sformatf("contend op%0d", op), expId ? 32'h40A00000 : 32'h40E00000, expId, 2);
      tick();
    end
`ifndef FPU_ARB_ROUND_ROBIN_EN
    checkOutput("contend req1 starved", {31'b0, sawReq1}, 32'h0);
`endif
    req0Valid = 1'b0; req1Valid = 1'b0;

    // A reset while EXEC is in progress must drop the operation.
    $display("[TB] reset during EXEC");
    tick();
    req0Valid = 1'b1; req0Frs1 = 32'h40200000; req0Frs2 = 32'h0; req0Funct = FUNCT_ADD;
    tick();
    req0Valid = 1'b0;
    #1;
    checkOutput("abort in EXEC fu_en", {31'b0, fuEn}, 32'h1);
    rst = 1'b1;
    tick();
    checkOutput("abort fu_en", {31'b0, fuEn}, 32'h0);
    checkOutput("abort rsp_valid", {31'b0, rspValid}, 32'h0);
    checkOutput("abort fu_frs1", fuFrs1, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("abort quiet c%0d", k), {31'b0, rspValid}, 32'h0);
    end
    applyStimulus("after abort", vecs[2]);

    // LAT=3: the unit inputs stay stable for 3 cycles, and rsp_valid
    // appears on the 4th edge.
    $display("[TB] LAT=3 instance");
    req0ValidL3 = 1'b1; req0Frs1L3 = 32'h41200000; req0Frs2L3 = 32'h40A00000;
    req0FunctL3 = FUNCT_SUB;
    #1;
    checkOutput("L3 ready", {31'b0, req0ReadyL3}, 32'h1);
    tick();
    req0ValidL3 = 1'b0; req0Frs1L3 = 32'hFFFFFFFF; req0Frs2L3 = 32'hFFFFFFFF;
    req0FunctL3 = FUNCT_ADD;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checkOutput($sformatf("L3 c%0d fu_en", k), {31'b0, fuEnL3}, 32'h1);
      checkOutput($sformatf("L3 c%0d fu_frs1", k), fuFrs1L3, 32'h41200000);
      checkOutput($sformatf("L3 c%0d fu_frs2", k), fuFrs2L3, 32'h40A00000);
      checkOutput($sformatf("L3 c%0d fu_funct", k), {31'b0, fuFunctL3}, {31'b0, FUNCT_SUB});
      checkOutput($sformatf("L3 c%0d rsp_valid", k), {31'b0, rspValidL3}, 32'h0);
      tick();
    end
    checkOutput("L3 rsp_valid", {31'b0, rspValidL3}, 32'h1);
    checkOutput("L3 rsp_frd", rspFrdL3, 32'h40A00000);
    checkOutput("L3 rsp_id", {31'b0, rspIdL3}, 32'h0);
    checkOutput("L3 fu_en off", {31'b0, fuEnL3}, 32'h0);
    tick();
    checkOutput("L3 rsp_valid cleared", {31'b0, rspValidL3}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
